us_dist_filter: RTL and testbench

Post-processing stage directly downstream of the ultrasonic distance calculator. It consumes each distance sample (`sample_vld` is the calculator's one-cycle done pulse) and keeps a 2^WIN_LOG2-sample moving average. It rejects timeout/error codes and raises a hysteretic proximity flag with an interrupt pulse. Outputs feed the APB register interface as a filtered-distance register, status and IRQ.

---
 rtl/us_pkg.sv | 20 ++
 rtl/us_win_buf.sv | 83 ++++++++
 rtl/us_dist_filter.sv | 146 ++++++++++++++
 tb/tb_us_dist_filter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/us_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | us_pkg: shared types and defaults for the ultrasonic distance filter |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
package us_pkg;

    localparam int DW_DEF       = 10;
    localparam int WIN_LOG2_DEF = 2;
    localparam int ERR_CODE_DEF = 1000;
    localparam int MAX_ERR_DEF  = 3;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/us_win_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | us_win_buf: N-entry circular sample window with running sum and fill |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module us_win_buf #(
    parameter int DW       = 10,
    parameter int WIN_LOG2 = 2
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   clr_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [DW-1:0]          value_i,
    output logic [DW+WIN_LOG2-1:0] sum_nxt_o,
    output logic [WIN_LOG2:0]      fill_o,
    output logic [WIN_LOG2:0]      fill_nxt_o
);

    localparam int                c_depth = 1 << WIN_LOG2;
    localparam logic [WIN_LOG2:0] c_full  = (WIN_LOG2+1)'(c_depth);

    logic [DW-1:0]          mem_q [c_depth];
    logic [DW-1:0]          mem_d [c_depth];
    logic [WIN_LOG2-1:0]    wp_q, wp_d;
    logic [DW+WIN_LOG2-1:0] sum_q, sum_d;
    logic [WIN_LOG2:0]      fill_q, fill_d;

    // Unwritten slots are always zero, so subtracting the slot under wp is
    // correct both while filling and once the window is full.
    always_comb begin
        mem_d  = mem_q;
        wp_d   = wp_q;
        sum_d  = sum_q;
        fill_d = fill_q;
        if (flush_i) begin
            for (int i = 0; i < c_depth; i++) begin
                mem_d[i] = '0;
            end
            wp_d   = '0;
            sum_d  = '0;
            fill_d = '0;
        end
        if (push_i) begin
            sum_d       = sum_d - {{WIN_LOG2{1'b0}}, mem_d[wp_d]} + {{WIN_LOG2{1'b0}}, value_i};
            mem_d[wp_d] = value_i;
            wp_d        = wp_d + WIN_LOG2'(1);
            if (fill_d != c_full) begin
                fill_d = fill_d + (WIN_LOG2+1)'(1);
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < c_depth; i++) begin
                mem_q[i] <= '0;
            end
            wp_q   <= '0;
            sum_q  <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < c_depth; i++) begin
                mem_q[i] <= '0;
            end
            wp_q   <= '0;
            sum_q  <= '0;
            fill_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wp_q   <= wp_d;
            sum_q  <= sum_d;
            fill_q <= fill_d;
        end
    end

    assign sum_nxt_o  = sum_d;
    assign fill_o     = fill_q;
    assign fill_nxt_o = fill_d;

endmodule
`default_nettype wire

// File: rtl/us_dist_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | us_dist_filter: moving-average distance filter, error reject, near IRQ |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module us_dist_filter
    import us_pkg::*;
#(
    parameter int DW       = us_pkg::DW_DEF,
    parameter int WIN_LOG2 = us_pkg::WIN_LOG2_DEF,
    parameter int ERR_CODE = us_pkg::ERR_CODE_DEF,
    parameter int MAX_ERR  = us_pkg::MAX_ERR_DEF
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                clr,
    input  logic                sample_vld,
    input  logic [DW-1:0]       sample_dist,
    input  logic [DW-1:0]       thr_near,
    input  logic [DW-1:0]       hyst,
    output logic [DW-1:0]       avg_dist,
    output logic                avg_vld,
    output logic                near_flag,
    output logic                irq,
    output logic                fault,
    output logic [WIN_LOG2:0]   fill
);

    localparam logic [WIN_LOG2:0] c_full     = (WIN_LOG2+1)'(1 << WIN_LOG2);
    localparam int                c_ew       = $clog2(MAX_ERR + 1);
    localparam logic [c_ew-1:0]   c_max_err  = c_ew'(MAX_ERR);
    localparam logic [31:0]       c_err_code = ERR_CODE;

    state_t                 state_q, state_d;
    logic [c_ew-1:0]        err_q, err_d;
    logic [DW-1:0]          avg_q, avg_d;
    logic                   avg_vld_q, avg_vld_d;
    logic                   near_q, near_d;
    logic                   irq_q, irq_d;
    logic                   fault_q, fault_d;

    logic                   w_push, w_flush, w_is_err;
    logic [DW+WIN_LOG2-1:0] w_sum_nxt;
    logic [WIN_LOG2:0]      w_fill_nxt;
    logic [DW-1:0]          w_avg_new;
    logic [DW:0]            w_clr_lvl;

    us_win_buf #(
        .DW       (DW),
        .WIN_LOG2 (WIN_LOG2)
    ) u_win_buf (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .clr_i      (clr),
        .flush_i    (w_flush),
        .push_i     (w_push),
        .value_i    (sample_dist),
        .sum_nxt_o  (w_sum_nxt),
        .fill_o     (fill),
        .fill_nxt_o (w_fill_nxt)
    );

    assign w_is_err  = (32'(sample_dist) >= c_err_code);
    assign w_avg_new = DW'(w_sum_nxt >> WIN_LOG2);
    // One extra bit keeps thr_near + hyst from wrapping.
    assign w_clr_lvl = {1'b0, thr_near} + {1'b0, hyst};

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        avg_d     = avg_q;
        avg_vld_d = 1'b0;
        near_d    = near_q;
        irq_d     = 1'b0;
        fault_d   = fault_q;
        w_push    = 1'b0;
        w_flush   = 1'b0;
        if (sample_vld) begin
            if (w_is_err) begin
                if (state_q != FAULT) begin
                    if (err_q != c_max_err) begin
                        err_d = err_q + c_ew'(1);
                    end
                    if (err_d == c_max_err) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end
            end else begin
                err_d  = '0;
                w_push = 1'b1;
                if (state_q == FAULT) begin
                    w_flush = 1'b1;
                    fault_d = 1'b0;
                    state_d = FILL;
                end else if (w_fill_nxt == c_full) begin
                    state_d   = RUN;
                    avg_d     = w_avg_new;
                    avg_vld_d = 1'b1;
                    if (w_avg_new < thr_near) begin
                        near_d = 1'b1;
                        irq_d  = ~near_q;
                    end else if ({1'b0, w_avg_new} >= w_clr_lvl) begin
                        near_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= FILL;
            err_q     <= '0;
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
            near_q    <= 1'b0;
            irq_q     <= 1'b0;
            fault_q   <= 1'b0;
        end else if (clr) begin
            state_q   <= FILL;
            err_q     <= '0;
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
            near_q    <= 1'b0;
            irq_q     <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            avg_q     <= avg_d;
            avg_vld_q <= avg_vld_d;
            near_q    <= near_d;
            irq_q     <= irq_d;
            fault_q   <= fault_d;
        end
    end

    assign avg_dist  = avg_q;
    assign avg_vld   = avg_vld_q;
    assign near_flag = near_q;
    assign irq       = irq_q;
    assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_us_dist_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_us_dist_filter: randomized and directed bench with queue model    |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_us_dist_filter;

    localparam int DW       = 10;
    localparam int WIN_LOG2 = 2;
    localparam int N        = 4;
    localparam int ERR_CODE = 1000;
    localparam int MAX_ERR  = 3;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              clr = 1'b0;
    logic              sample_vld = 1'b0;
    logic [DW-1:0]     sample_dist = '0;
    logic [DW-1:0]     thr_near = '0;
    logic [DW-1:0]     hyst = '0;
    logic [DW-1:0]     avg_dist;
    logic              avg_vld;
    logic              near_flag;
    logic              irq;
    logic              fault;
    logic [WIN_LOG2:0] fill;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: window as a queue of accepted samples.
    int m_win[$];
    int m_err;
    bit m_fault;
    int e_avg;
    bit e_vld, e_near, e_irq;

    always #5 PCLK = ~PCLK;

    us_dist_filter #(
        .DW       (DW),
        .WIN_LOG2 (WIN_LOG2),
        .ERR_CODE (ERR_CODE),
        .MAX_ERR  (MAX_ERR)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .clr         (clr),
        .sample_vld  (sample_vld),
        .sample_dist (sample_dist),
        .thr_near    (thr_near),
        .hyst        (hyst),
        .avg_dist    (avg_dist),
        .avg_vld     (avg_vld),
        .near_flag   (near_flag),
        .irq         (irq),
        .fault       (fault),
        .fill        (fill)
    );

    function automatic void model_clear();
        m_win.delete();
        m_err   = 0;
        m_fault = 1'b0;
        e_avg   = 0;
        e_vld   = 1'b0;
        e_near  = 1'b0;
        e_irq   = 1'b0;
    endfunction

    function automatic logic [DW+6:0] exp_vec();
        return {e_vld, DW'(e_avg), e_near, e_irq, m_fault, 3'(m_win.size())};
    endfunction

    function automatic logic [DW+6:0] got_vec();
        return {avg_vld, avg_dist, near_flag, irq, fault, fill};
    endfunction

    function automatic string exp_str();
        return $sformatf("vld=%0d avg=%0d near=%0d irq=%0d fault=%0d fill=%0d",
                         e_vld, e_avg, e_near, e_irq, m_fault, m_win.size());
    endfunction

    function automatic string got_str();
        return $sformatf("vld=%0d avg=%0d near=%0d irq=%0d fault=%0d fill=%0d",
                         avg_vld, avg_dist, near_flag, irq, fault, fill);
    endfunction

    // Drive one cycle of inputs, advance the model, and stop 1 ns past the edge.
    task automatic apply(input bit v, input int d, input bit c);
        int s;
        sample_vld  = v;
        sample_dist = DW'(d);
        clr         = c;
        e_vld       = 1'b0;
        e_irq       = 1'b0;
        if (c) begin
            model_clear();
        end else if (v) begin
            if (d >= ERR_CODE) begin
                if (!m_fault) begin
                    m_err++;
                    if (m_err >= MAX_ERR) m_fault = 1'b1;
                end
            end else begin
                m_err = 0;
                if (m_fault) begin
                    m_win.delete();
                    m_fault = 1'b0;
                end
                m_win.push_back(d);
                if (m_win.size() > N) void'(m_win.pop_front());
                if (m_win.size() == N) begin
                    s = 0;
                    foreach (m_win[i]) s += m_win[i];
                    e_avg = s / N;
                    e_vld = 1'b1;
                    if (e_avg < int'(thr_near)) begin
                        if (!e_near) e_irq = 1'b1;
                        e_near = 1'b1;
                    end else if (e_avg >= int'(thr_near) + int'(hyst)) begin
                        e_near = 1'b0;
                    end
                end
            end
        end
        @(posedge PCLK);
        #1;
        sample_vld = 1'b0;
        clr        = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (got_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got %s, expected all zero", got_str());
        end
        PRESET = 1'b0;
        model_clear();
        apply(1'b0, 0, 1'b0);
        n_tests++;
        if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %s, expected %s", got_str(), exp_str());
        end
    endtask

    task automatic test_average();
        int seq[6] = '{100, 104, 108, 112, 120, 200};
        thr_near = 10'd0;
        hyst     = 10'd0;
        foreach (seq[i]) begin
            apply(1'b1, seq[i], 1'b0);
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL average step %0d: got %s, expected %s", i, got_str(), exp_str());
            end
            if (i == 3) begin
                n_tests++;
                if (avg_vld !== 1'b1 || avg_dist !== 10'd106 || fill !== 3'd4) begin
                    n_fail++;
                    $display("FAIL first_avg: got %s, expected vld=1 avg=106 fill=4", got_str());
                end
            end
            if (i == 4) begin
                n_tests++;
                if (avg_dist !== 10'd111) begin
                    n_fail++;
                    $display("FAIL evict_avg: got avg=%0d, expected 111", avg_dist);
                end
            end
            apply(1'b0, 0, 1'b0);
            n_tests++;
            if (avg_vld !== 1'b0 || avg_dist !== DW'(e_avg)) begin
                n_fail++;
                $display("FAIL avg_hold step %0d: got %s, expected %s", i, got_str(), exp_str());
            end
        end
    endtask

    task automatic test_hysteresis();
        int irq_cnt = 0;
        thr_near = 10'd50;
        hyst     = 10'd10;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < N; k++) begin
                apply(1'b1, (p == 0) ? 40 : (p == 1) ? 55 : 60, 1'b0);
                irq_cnt += int'(irq);
                n_tests++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL hyst p%0d k%0d: got %s, expected %s", p, k, got_str(), exp_str());
                end
            end
            n_tests++;
            if (near_flag !== (p != 2) || irq_cnt != ((p == 0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL hyst_phase %0d: got near=%0d irqs=%0d, expected near=%0d irqs=%0d",
                         p, near_flag, irq_cnt, (p != 2), (p == 0) ? 1 : 0);
            end
            irq_cnt = 0;
        end
    endtask

    task automatic test_fault();
        logic [DW-1:0] held;
        held = avg_dist;
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, ERR_CODE + k * 10, 1'b0);
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL fault_err %0d: got %s, expected %s", k, got_str(), exp_str());
            end
        end
        n_tests++;
        if (fault !== 1'b1 || avg_dist !== held) begin
            n_fail++;
            $display("FAIL fault_set: got fault=%0d avg=%0d, expected fault=1 avg=%0d", fault, avg_dist, held);
        end
        apply(1'b1, 1023, 1'b0);
        apply(1'b1, 80, 1'b0);
        n_tests++;
        if (fault !== 1'b0 || fill !== 3'd1 || avg_vld !== 1'b0 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL fault_recover: got %s, expected %s", got_str(), exp_str());
        end
    endtask

    task automatic test_err_reset();
        int seq[4] = '{1000, 90, 1000, 1000};
        foreach (seq[i]) begin
            apply(1'b1, seq[i], 1'b0);
            n_tests++;
            if (got_vec() !== exp_vec() || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL err_reset step %0d: got %s, expected %s", i, got_str(), exp_str());
            end
        end
    endtask

    task automatic test_back_to_back();
        apply(1'b0, 0, 1'b1);
        n_tests++;
        if (got_vec() !== '0) begin
            n_fail++;
            $display("FAIL clr_start: got %s, expected all zero", got_str());
        end
        for (int k = 1; k <= 4; k++) begin
            apply(1'b1, 10 * k, 1'b0);
            n_tests++;
            if (got_vec() !== exp_vec() || avg_vld !== (k == 4)) begin
                n_fail++;
                $display("FAIL b2b %0d: got %s, expected %s", k, got_str(), exp_str());
            end
        end
        n_tests++;
        if (avg_dist !== 10'd25) begin
            n_fail++;
            $display("FAIL b2b_avg: got avg=%0d, expected 25", avg_dist);
        end
        apply(1'b1, 70, 1'b0);
        apply(1'b1, 70, 1'b1);
        n_tests++;
        if (got_vec() !== '0) begin
            n_fail++;
            $display("FAIL clr_mid: got %s, expected all zero", got_str());
        end
        for (int k = 0; k < 5; k++) apply(1'b1, 20 + k, 1'b0);
        #2;
        PRESET = 1'b1;
        #1;
        n_tests++;
        if (got_vec() !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %s, expected all zero", got_str());
        end
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        model_clear();
        apply(1'b1, 33, 1'b0);
        n_tests++;
        if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL post_reset: got %s, expected %s", got_str(), exp_str());
        end
    endtask

    task automatic test_random();
        bit v, c;
        int d;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                thr_near = DW'($urandom_range(100, 700));
                hyst     = DW'($urandom_range(0, 300));
            end
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 99) == 0);
            d = ($urandom_range(0, 9) < 2) ? $urandom_range(ERR_CODE, 1023) : $urandom_range(0, 999);
            apply(v, d, c);
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random %0d (v=%0d d=%0d c=%0d): got %s, expected %s",
                         i, v, d, c, got_str(), exp_str());
            end
        end
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge PCLK);
        #1;
        test_reset();
        test_average();
        test_hysteresis();
        test_fault();
        test_err_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
